// File: rtl/min_finder_32_d_if.sv
// min_finder_32_d_if: vector-in / min-sum-result-out handshake bundle for the check-node min finder.
interface min_finder_32_d_if #(
  parameter int W    = 6,
  parameter int Wc   = 32,
  parameter int IDXW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [W*Wc-1:0]   q_in;
  logic              out_valid;
  logic              out_ready;
  logic [W-2:0]      min1;
  logic [W-2:0]      min2;
  logic [IDXW-1:0]   min1_idx;
  logic              sign_prod;
  logic [Wc-1:0]     sign_vec;
  modport master (
    output in_valid, q_in, out_ready,
    input  in_ready, out_valid, min1, min2, min1_idx, sign_prod, sign_vec
  );
  modport slave (
    input  in_valid, q_in, out_ready,
    output in_ready, out_valid, min1, min2, min1_idx, sign_prod, sign_vec
  );
endinterface

// File: rtl/min_finder_32_d.sv
// min_finder_32_d: scans a latched vector LANES elements per cycle for min1/min2/min1_idx and sign info.
module min_finder_32_d #(
  parameter int W     = 6,
  parameter int Wc    = 32,
  parameter int LANES = 4,
  parameter int IDXW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  min_finder_32_d_if.slave  bus_if
);
  localparam int NCH = Wc / LANES;
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t            state_q, state_d;
  logic [W*Wc-1:0]   q_q, q_d;
  logic [W-2:0]      min1_q, min1_d, min2_q, min2_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              sp_q, sp_d;
  logic [Wc-1:0]     sv_q, sv_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic [W-2:0]      s_min1, s_min2;
  logic [IDXW-1:0]   s_idx;
  logic              s_sp;
  logic [Wc-1:0]     s_sv;
  // -2^(W-1) has no positive counterpart, so it saturates to the largest magnitude
  function automatic logic [W-2:0] mag_f(input logic [W-1:0] e);
    return e[W-1] ? ((e[W-2:0] == '0) ? '1 : (~e[W-2:0] + (W-1)'(1))) : e[W-2:0];
  endfunction
  always_comb begin
    int k;
    logic [W-1:0] e;
    logic [W-2:0] m;
    s_min1 = min1_q;
    s_min2 = min2_q;
    s_idx  = idx_q;
    s_sp   = sp_q;
    s_sv   = sv_q;
    for (int l = 0; l < LANES; l++) begin
      k = int'(chunk_q) * LANES + l;
      e = q_q[k*W +: W];
      m = mag_f(e);
      if (m < s_min1) begin
        s_min2 = s_min1;
        s_min1 = m;
        s_idx  = IDXW'(k);
      end else if (m < s_min2) begin
        s_min2 = m;
      end
      s_sv[k] = e[W-1];
      s_sp    = s_sp ^ e[W-1];
    end
  end
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    sp_d    = sp_q;
    sv_d    = sv_q;
    chunk_d = chunk_q;
    unique case (state_q)
      IDLE: if (bus_if.in_valid) begin
        state_d = SCAN;
        q_d     = bus_if.q_in;
        min1_d  = '1;
        min2_d  = '1;
        idx_d   = '0;
        sp_d    = 1'b0;
        sv_d    = '0;
        chunk_d = '0;
      end
      SCAN: begin
        min1_d  = s_min1;
        min2_d  = s_min2;
        idx_d   = s_idx;
        sp_d    = s_sp;
        sv_d    = s_sv;
        chunk_d = chunk_q + CW'(1);
        state_d = (chunk_q == CW'(NCH - 1)) ? DONE : SCAN;
      end
      DONE: state_d = bus_if.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      idx_q   <= '0;
      sp_q    <= 1'b0;
      sv_q    <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
      sv_q    <= sv_d;
      chunk_q <= chunk_d;
    end
  end
  assign bus_if.in_ready  = (state_q == IDLE) & rst;
  assign bus_if.out_valid = (state_q == DONE);
  assign bus_if.min1      = min1_q;
  assign bus_if.min2      = min2_q;
  assign bus_if.min1_idx  = idx_q;
  assign bus_if.sign_prod = sp_q;
  assign bus_if.sign_vec  = sv_q;
endmodule
